vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing for the Go Board snake display from the 25 MHz board clock.
- Drives the pixel coordinates (x, y) and active-video qualifier that the game renderer consumes.
- Drives the hsync/vsync pins.
- Produces the frame-derived game tick that advances the snake.

Parameters:
- CLK_DIV, 1, clk cycles per pixel (1 = clk is pixel clock; 2 for a 50 MHz clk).
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal pixel counts; H_TOTAL = sum = 800.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical line counts; V_TOTAL = sum = 525.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low, VGA standard).
- TICK_FRAMES, 6, frames per game tick; legal range 1..63.

Ports:
- clk  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-high reset
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- tick  out  1  one-clk-cycle game-advance pulse
- (SPEED_CTRL_EN only) speed  in  6  runtime frames-per-tick

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - x=0, y=0, tick=0, hsync=vsync=deasserted (!SYNC_POL), active=0.
  - Internal div_cnt=0, frm_cnt=0, run=0.
- run is set on the first clk edge after reset deasserts.
- active/hsync/vsync are decodes of the registered x/y, gated by run, so they are always aligned with the x/y presented in the same cycle.
  - Consequence: only the very first pixel (0,0) after reset reads inactive.
- Pixel enable: pe=1 when div_cnt==CLK_DIV-1. div_cnt wraps to 0 on pe. With CLK_DIV=1, pe is constant 1.
- Counters advance on pe only:
  - x increments; at x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 with the x wrap, y wraps to 0 (frame wrap).
- Sync windows (counts inclusive..exclusive):
  - hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - vsync asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492), all x on those lines.
- Frame counter: frm_cnt (6 bit) is evaluated at each frame wrap.
  - If frm_cnt >= N-1 (N = TICK_FRAMES): frm_cnt<=0 and tick<=1 for exactly one clk cycle, coincident with x=0,y=0.
  - Otherwise frm_cnt increments.
  - N=1 gives a tick every frame.
- tick is a clean one-clk pulse regardless of CLK_DIV. It is never asserted on two consecutive clk cycles.
- Tick period is N*800*525*CLK_DIV clk cycles (default 2,520,000 = 10 Hz).
- Reset mid-frame: all counters return to 0 immediately (async). A pending tick is cancelled. The first tick after release comes N full frames later.
- Widths: x/y comparisons are unsigned 10 bit. H_TOTAL and V_TOTAL must be <= 1024.

Optional Feature:
- Macro: SPEED_CTRL_EN.
- Defined:
  - Adds port speed[5:0]. Effective N is sampled from speed at every frame wrap (before the compare); speed==0 is treated as 1.
  - Lowering speed below the current frm_cnt+1 fires tick at the next wrap (>= compare) and never stalls.
  - TICK_FRAMES is ignored.
- Undefined: no speed port; N = TICK_FRAMES constant.

Test Plan:
- Reset release, CLK_DIV=1: x counts 0..799 then 0, y increments at wrap; a full frame is 420,000 clk cycles; y=524->0 at frame end.
- Sync check: hsync low exactly for x=656..751 (96 px) every line; vsync low for all of y=490..491 (1600 clk); active high for 307,200 cycles per frame.
- Tick default (N=6): first tick 6 frames after reset (2,520,000 clk); pulse width 1 clk; subsequent period 2,520,000; tick coincides with x=0,y=0.
- CLK_DIV=2: x holds each value 2 clk cycles; frame = 840,000 clk; tick width still 1 clk.
- Async reset asserted at x=300,y=200 for 3 cycles: x=y=0, hsync=vsync=1, tick=0 immediately; first tick after release 6 frames later.
- SPEED_CTRL_EN: speed=10, then speed=2 written when frm_cnt=7 -> tick at next frame wrap; afterwards a tick every 2 frames; speed=0 -> tick every frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel coordinates, active video, syncs and a frame-derived game tick.
// Optional macro SPEED_CTRL_EN adds a runtime frames-per-tick input (speed) in place of TICK_FRAMES.
module vga_timing_gen #(
  parameter int CLK_DIV     = 1,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int TICK_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset,
`ifdef SPEED_CTRL_EN
  input  logic [5:0] speed,
`endif
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       frm_cnt;
  logic [5:0]       n_last;
  logic             run;
  logic             pe;
  logic             in_hs;
  logic             in_vs;

  assign pe = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef SPEED_CTRL_EN
  // speed==0 behaves as one frame per tick
  assign n_last = (speed == 6'd0) ? 6'd0 : speed - 6'd1;
`else
  assign n_last = 6'(TICK_FRAMES - 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      x       <= '0;
      y       <= '0;
      frm_cnt <= '0;
      tick    <= 1'b0;
      run     <= 1'b0;
    end else begin
      run  <= 1'b1;
      tick <= 1'b0;
      if (pe) begin
        div_cnt <= '0;
        if (x == H_LAST) begin
          x <= '0;
          if (y == V_LAST) begin
            y <= '0;
            // >= so that a lowered speed fires at this wrap instead of stalling
            if (frm_cnt >= n_last) begin
              frm_cnt <= '0;
              tick    <= 1'b1;
            end else begin
              frm_cnt <= frm_cnt + 6'd1;
            end
          end else begin
            y <= y + 10'd1;
          end
        end else begin
          x <= x + 10'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Decodes of the registered counters so they line up with the x/y shown this cycle
  assign in_hs  = (x >= HS_BEG) && (x < HS_END);
  assign in_vs  = (y >= VS_BEG) && (y < VS_END);
  assign active = run && (x < H_ACT) && (y < V_ACT);
  assign hsync  = (run && in_hs) ? SYNC_POL : ~SYNC_POL;
  assign vsync  = (run && in_vs) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (15x10) so ticks and resets fit a short run.
// u0: CLK_DIV=1, active-low syncs, 3 frames/tick. u1: CLK_DIV=2, active-high syncs, 1 frame/tick.
module tb_vga_timing_gen;
  localparam int HT = 15;
  localparam int VT = 10;

  logic       clk;
  logic       reset;
  logic [9:0] x0, y0, x1, y1;
  logic       active0, hsync0, vsync0, tick0;
  logic       active1, hsync1, vsync1, tick1;
`ifdef SPEED_CTRL_EN
  logic [5:0] speed0 = 6'd3;
  logic [5:0] speed1 = 6'd1;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [47:0] exp_q[$];

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .TICK_FRAMES(3)
  ) u0 (
    .clk(clk), .reset(reset),
`ifdef SPEED_CTRL_EN
    .speed(speed0),
`endif
    .x(x0), .y(y0), .active(active0), .hsync(hsync0), .vsync(vsync0), .tick(tick0)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .TICK_FRAMES(1)
  ) u1 (
    .clk(clk), .reset(reset),
`ifdef SPEED_CTRL_EN
    .speed(speed1),
`endif
    .x(x1), .y(y1), .active(active1), .hsync(hsync1), .vsync(vsync1), .tick(tick1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form expectation from clk cycles since reset release
  function automatic logic [23:0] model(int k, int div, int n, bit pol);
    int p, mx, my;
    logic run, a, hs, vs, tk;
    p   = k / div;
    mx  = p % HT;
    my  = (p / HT) % VT;
    run = (k > 0);
    a   = run && (mx < 8) && (my < 6);
    hs  = (run && mx >= 10 && mx < 13) ? pol : !pol;
    vs  = (run && my >= 7 && my < 9) ? pol : !pol;
    tk  = (k > 0) && ((k % (n * HT * VT * div)) == 0);
    return {10'(mx), 10'(my), a, hs, vs, tk};
  endfunction

  function automatic logic [47:0] reset_exp();
    return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic test_reset();
    logic [47:0] got, expv;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_q.push_back(reset_exp());
      got  = {x0, y0, active0, hsync0, vsync0, tick0, x1, y1, active1, hsync1, vsync1, tick1};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, got, expv);
      end
    end
  endtask

  task automatic release_reset();
    logic [47:0] got, expv;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    exp_q.push_back({model(0, 1, 3, 1'b0), model(0, 2, 1, 1'b1)});
    got  = {x0, y0, active0, hsync0, vsync0, tick0, x1, y1, active1, hsync1, vsync1, tick1};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL release cyc=0 got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_raster(int n);
    logic [47:0] got, expv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      exp_q.push_back({model(cyc, 1, 3, 1'b0), model(cyc, 2, 1, 1'b1)});
      got  = {x0, y0, active0, hsync0, vsync0, tick0, x1, y1, active1, hsync1, vsync1, tick1};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL raster cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
    end
  endtask

  // Window totals over 300 clk (two u0 frames, one u1 frame)
  task automatic test_sync_counts();
    int hs0 = 0, vs0 = 0, ac0 = 0, hs1 = 0, vs1 = 0, ac1 = 0, tk1 = 0, dbl = 0;
    logic p0 = 1'b0, p1 = 1'b0;
    logic [47:0] got, expv;
    exp_q.push_back({16'd60, 16'd60, 16'd96});
    exp_q.push_back({16'd60, 16'd60, 16'd96});
    exp_q.push_back({16'd1, 16'd0, 16'd0});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (!hsync0) hs0++;
      if (!vsync0) vs0++;
      if (active0) ac0++;
      if (hsync1) hs1++;
      if (vsync1) vs1++;
      if (active1) ac1++;
      if (tick1) tk1++;
      if ((tick0 && p0) || (tick1 && p1)) dbl++;
      p0 = tick0;
      p1 = tick1;
    end
    got  = {16'(hs0), 16'(vs0), 16'(ac0)};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL counts_u0 hs/vs/act got=%h exp=%h", got, expv);
    end
    got  = {16'(hs1), 16'(vs1), 16'(ac1)};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL counts_u1 hs/vs/act got=%h exp=%h", got, expv);
    end
    got  = {16'(tk1), 16'(dbl), 16'd0};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL ticks_u1 tick/double got=%h exp=%h", got, expv);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge
  task automatic test_async_reset(string tag);
    logic [47:0] got, expv;
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(reset_exp());
    got  = {x0, y0, active0, hsync0, vsync0, tick0, x1, y1, active1, hsync1, vsync1, tick1};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s_async got=%h exp=%h", tag, got, expv);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_q.push_back(reset_exp());
      got  = {x0, y0, active0, hsync0, vsync0, tick0, x1, y1, active1, hsync1, vsync1, tick1};
      expv = exp_q.pop_front();
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL %s_hold i=%0d got=%h exp=%h", tag, i, got, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    release_reset();
    test_raster(2000);
    test_sync_counts();
    // u0 now sits mid-frame at x=5, y=3
    test_async_reset("midframe");
    release_reset();
    test_raster(1350);
    // cyc=1350 is a u0 tick cycle: reset must cancel it
    test_async_reset("tick_cancel");
    release_reset();
    test_raster(460);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
